// File: rtl/core_pipe_pkg.sv
// Shared types and constants for core pipeline stage registers.
// Holds the NOP encoding, the default payload widths and the stage occupancy state type.
package core_pipe_pkg;

    localparam int unsigned DefInstrW = 32;
    localparam int unsigned DefPcW    = 32;

    // addi x0, x0, 0: a bubble decodes as a harmless NOP
    localparam logic [31:0] NopInstr = 32'h0000_0013;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream valid-ready handshake of one pipeline stage register.
// The slave modport is the stage itself; the master modport is its environment.
interface pipe_stage_reg_if
    import core_pipe_pkg::*;
#(
    parameter int unsigned INSTR_W = DefInstrW,
    parameter int unsigned PC_W    = DefPcW
) ();

    logic               up_valid_i;
    logic               up_ready_o;
    logic [INSTR_W-1:0] up_instr_i;
    logic [PC_W-1:0]    up_pc_i;
    logic               dn_valid_o;
    logic               dn_ready_i;
    logic [INSTR_W-1:0] dn_instr_o;
    logic [PC_W-1:0]    dn_pc_o;

    modport slave (
        input  up_valid_i, up_instr_i, up_pc_i, dn_ready_i,
        output up_ready_o, dn_valid_o, dn_instr_o, dn_pc_o
    );

    modport master (
        output up_valid_i, up_instr_i, up_pc_i, dn_ready_i,
        input  up_ready_o, dn_valid_o, dn_instr_o, dn_pc_o
    );

endinterface

// File: rtl/pipe_payload_reg.sv
// Width-parametrised enable register with an asynchronous active-low reset
// whose reset value is supplied as an input.
module pipe_payload_reg #(
    parameter int unsigned Width = 64
) (
    input  logic             clk_i,
    input  logic             rsn_i,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    input  logic [Width-1:0] rst_val_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] data_q;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            data_q <= rst_val_i;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline register between two core stages with valid/ready handshake, flush and stall.
// SKID_EN adds a second entry so that up_ready_o depends only on registered state and stall.
module pipe_stage_reg
    import core_pipe_pkg::*;
#(
    parameter int unsigned        INSTR_W   = DefInstrW,
    parameter int unsigned        PC_W      = DefPcW,
    parameter bit                 SKID_EN   = 1'b1,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NopInstr)
) (
    input  logic             clk_i,
    input  logic             rsn_i,
    input  logic             stall_i,
    input  logic             flush_i,
    pipe_stage_reg_if.slave  bus
);

    localparam int unsigned PayW = INSTR_W + PC_W;

    state_e            state_q, state_d;
    logic              rdy_q;
    logic              main_valid, skid_valid;
    logic              up_ready, acc, take;
    logic              main_load, skid_load, main_from_skid;
    logic [PayW-1:0]   up_pay, main_d, main_q, skid_q;

    assign main_valid = (state_q != StEmpty);
    assign skid_valid = (state_q == StTwo);

    // rdy_q keeps up_ready_o low throughout reset and for the release cycle
    if (SKID_EN) begin : g_skid_ready
        assign up_ready = rdy_q & ~skid_valid & ~stall_i;
    end else begin : g_pass_ready
        assign up_ready = rdy_q & (~main_valid | bus.dn_ready_i) & ~stall_i;
    end

    // Flush kills the payload offered in the same cycle as well as everything held
    assign acc  = bus.up_valid_i & up_ready & ~flush_i;
    assign take = main_valid & bus.dn_ready_i & ~stall_i & ~flush_i;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush_i) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (acc) begin
                        state_d   = StOne;
                        main_load = 1'b1;
                    end
                end
                StOne: begin
                    if (acc && take) begin
                        main_load = 1'b1;
                    end else if (acc) begin
                        state_d   = StTwo;
                        skid_load = 1'b1;
                    end else if (take) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (take) begin
                        state_d        = StOne;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q <= StEmpty;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
        end
    end

    assign up_pay = {bus.up_instr_i, bus.up_pc_i};
    assign main_d = main_from_skid ? skid_q : up_pay;

    pipe_payload_reg #(
        .Width (PayW)
    ) u_main (
        .clk_i     (clk_i),
        .rsn_i     (rsn_i),
        .en_i      (main_load),
        .d_i       (main_d),
        .rst_val_i ({NOP_INSTR, {PC_W{1'b0}}}),
        .q_o       (main_q)
    );

    pipe_payload_reg #(
        .Width (PayW)
    ) u_skid (
        .clk_i     (clk_i),
        .rsn_i     (rsn_i),
        .en_i      (skid_load),
        .d_i       (up_pay),
        .rst_val_i ({PayW{1'b0}}),
        .q_o       (skid_q)
    );

    assign bus.up_ready_o = up_ready;
    assign bus.dn_valid_o = main_valid;
    assign bus.dn_instr_o = main_valid ? main_q[PayW-1:PC_W] : NOP_INSTR;
    assign bus.dn_pc_o    = main_q[PC_W-1:0];

    a_skid_implies_main: assert property (
        @(posedge clk_i) disable iff (!rsn_i) skid_valid |-> main_valid);

    if (!SKID_EN) begin : g_no_two
        a_never_two: assert property (
            @(posedge clk_i) disable iff (!rsn_i) state_q != StTwo);
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a pass-through instance run side by side
// against a queue-based reference model, with directed steps followed by random traffic.
module tb_pipe_stage_reg;

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic clk;
    logic rsn;
    bit   uv [2];
    bit   dr [2];
    bit   st [2];
    bit   fl [2];
    logic [31:0] ui [2];
    logic [31:0] up [2];

    int checks = 0;
    int errors = 0;

    // Reference model: ordered queue of held {instr, pc}, last pc seen at the output
    logic [63:0] mq0 [$];
    logic [63:0] mq1 [$];
    logic [31:0] lpc [2];
    bit          ren [2];

    pipe_stage_reg_if #(.INSTR_W(32), .PC_W(32)) bus0 ();
    pipe_stage_reg_if #(.INSTR_W(32), .PC_W(32)) bus1 ();

    assign bus0.up_valid_i = uv[0];
    assign bus0.up_instr_i = ui[0];
    assign bus0.up_pc_i    = up[0];
    assign bus0.dn_ready_i = dr[0];
    assign bus1.up_valid_i = uv[1];
    assign bus1.up_instr_i = ui[1];
    assign bus1.up_pc_i    = up[1];
    assign bus1.dn_ready_i = dr[1];

    pipe_stage_reg #(.INSTR_W(32), .PC_W(32), .SKID_EN(1'b0), .NOP_INSTR(32'h0000_0013)) u_pass (
        .clk_i   (clk),
        .rsn_i   (rsn),
        .stall_i (st[0]),
        .flush_i (fl[0]),
        .bus     (bus0)
    );

    pipe_stage_reg #(.INSTR_W(32), .PC_W(32), .SKID_EN(1'b1), .NOP_INSTR(32'h0000_0013)) u_skid (
        .clk_i   (clk),
        .rsn_i   (rsn),
        .stall_i (st[1]),
        .flush_i (fl[1]),
        .bus     (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic get_v(input int m);
        return m != 0 ? bus1.dn_valid_o : bus0.dn_valid_o;
    endfunction
    function automatic logic get_r(input int m);
        return m != 0 ? bus1.up_ready_o : bus0.up_ready_o;
    endfunction
    function automatic logic [31:0] get_i(input int m);
        return m != 0 ? bus1.dn_instr_o : bus0.dn_instr_o;
    endfunction
    function automatic logic [31:0] get_p(input int m);
        return m != 0 ? bus1.dn_pc_o : bus0.dn_pc_o;
    endfunction

    function automatic int qsize(input int m);
        return m != 0 ? mq1.size() : mq0.size();
    endfunction
    function automatic logic [63:0] qfront(input int m);
        return m != 0 ? mq1[0] : mq0[0];
    endfunction

    // Capacity is two entries with a skid buffer, otherwise one entry that may be
    // replaced in the same cycle it is consumed
    function automatic bit exp_ready(input int m);
        if (!ren[m] || st[m]) return 1'b0;
        if (m != 0) return qsize(m) < 2;
        return qsize(m) == 0 || dr[m];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int m);
        string s;
        int    sz;
        logic [63:0] fr;
        s  = (m != 0) ? "skid" : "pass";
        sz = qsize(m);
        fr = (sz > 0) ? qfront(m) : 64'h0;
        chk({s, " dn_valid"}, 64'(get_v(m)), 64'(sz > 0));
        chk({s, " dn_instr"}, 64'(get_i(m)), (sz > 0) ? 64'(fr[63:32]) : 64'(Nop));
        chk({s, " dn_pc"},    64'(get_p(m)), (sz > 0) ? 64'(fr[31:0]) : 64'(lpc[m]));
        chk({s, " up_ready"}, 64'(get_r(m)), 64'(exp_ready(m)));
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        for (int m = 0; m < 2; m++) begin
            lpc[m] = 32'h0;
            ren[m] = 1'b0;
        end
    endtask

    // Called with the clock low; checks outputs, then advances DUTs and model by one edge
    task automatic step();
        bit acc [2];
        bit take [2];
        #1;
        check_dut(0);
        check_dut(1);
        for (int m = 0; m < 2; m++) begin
            acc[m]  = uv[m] && exp_ready(m) && !fl[m];
            take[m] = qsize(m) > 0 && dr[m] && !st[m] && !fl[m];
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (fl[m]) begin
                if (m != 0) mq1.delete(); else mq0.delete();
            end else begin
                if (take[m]) begin
                    if (m != 0) void'(mq1.pop_front()); else void'(mq0.pop_front());
                end
                if (acc[m]) begin
                    if (m != 0) mq1.push_back({ui[m], up[m]});
                    else mq0.push_back({ui[m], up[m]});
                end
            end
            if (qsize(m) > 0) lpc[m] = qfront(m) >> 0;
            if (qsize(m) > 0) lpc[m] = lpc[m] & 32'hFFFF_FFFF;
            if (rsn) ren[m] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit rdy);
        for (int m = 0; m < 2; m++) begin
            uv[m] = v;
            up[m] = pc;
            ui[m] = pc ^ 32'hC0DE_0000;
            dr[m] = rdy;
        end
    endtask

    initial begin
        int seq;
        rsn = 1'b0;
        for (int m = 0; m < 2; m++) begin
            st[m] = 1'b0;
            fl[m] = 1'b0;
        end
        drive(1'b0, 32'h0, 1'b0);
        model_reset();
        #1;
        check_dut(0);
        check_dut(1);
        @(negedge clk);
        rsn = 1'b1;
        step();
        chk("first cycle ready", 64'(get_r(1)), 64'h1);

        // Fill the stage, then reset asynchronously in the middle of a cycle
        drive(1'b1, 32'h100, 1'b0);
        step();
        drive(1'b1, 32'h104, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        #2;
        rsn = 1'b0;
        model_reset();
        #1;
        chk("async rst valid", 64'(get_v(1)), 64'h0);
        chk("async rst instr", 64'(get_i(1)), 64'(Nop));
        check_dut(0);
        check_dut(1);
        @(negedge clk);
        rsn = 1'b1;
        step();
        chk("ready after release", 64'(get_r(1)), 64'h1);

        // Streaming with downstream always ready
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'(k * 4), 1'b1);
            step();
            chk("stream pc", 64'(get_p(1)), 64'(k * 4));
        end
        drive(1'b0, 32'h0, 1'b1);
        step();
        step();

        // Skid fill and drain
        drive(1'b1, 32'h10, 1'b0);
        step();
        drive(1'b1, 32'h14, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        #1;
        chk("skid full ready", 64'(get_r(1)), 64'h0);
        chk("skid full pc", 64'(get_p(1)), 64'h10);
        dr[0] = 1'b1;
        dr[1] = 1'b1;
        step();
        chk("skid drain pc", 64'(get_p(1)), 64'h14);
        chk("skid drain ready", 64'(get_r(1)), 64'h1);
        step();
        step();

        // Stall with a held entry and downstream ready
        drive(1'b1, 32'h20, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b1);
        st[0] = 1'b1;
        st[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall pc", 64'(get_p(1)), 64'h20);
            chk("stall ready", 64'(get_r(1)), 64'h0);
        end
        st[0] = 1'b0;
        st[1] = 1'b0;
        step();
        step();

        // Flush beats accept while full
        drive(1'b1, 32'h30, 1'b0);
        step();
        drive(1'b1, 32'h34, 1'b0);
        step();
        drive(1'b1, 32'h40, 1'b0);
        fl[0] = 1'b1;
        fl[1] = 1'b1;
        step();
        fl[0] = 1'b0;
        fl[1] = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        #1;
        chk("flush valid", 64'(get_v(1)), 64'h0);
        chk("flush instr", 64'(get_i(1)), 64'(Nop));
        chk("flush pc kept", 64'(get_p(1)), 64'h30);
        step();
        step();

        // Pass-through ready follows dn_ready_i combinationally
        drive(1'b1, 32'h50, 1'b1);
        step();
        drive(1'b1, 32'h54, 1'b1);
        #1;
        chk("pass ready hi", 64'(get_r(0)), 64'h1);
        dr[0] = 1'b0;
        #1;
        chk("pass ready lo", 64'(get_r(0)), 64'h0);
        dr[0] = 1'b1;
        step();
        drive(1'b1, 32'h58, 1'b1);
        step();
        chk("pass b2b pc", 64'(get_p(0)), 64'h58);
        drive(1'b0, 32'h0, 1'b1);
        step();

        // Random handshake traffic against the model
        seq = 1024;
        for (int n = 0; n < 10000; n++) begin
            for (int m = 0; m < 2; m++) begin
                uv[m] = $urandom_range(0, 9) < 7;
                dr[m] = $urandom_range(0, 9) < 6;
                st[m] = $urandom_range(0, 9) == 0;
                fl[m] = $urandom_range(0, 49) == 0;
                up[m] = 32'(seq * 4);
                ui[m] = $urandom;
                seq++;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
